stream_mux_rr: RTL and testbench

- Parametrised successor to the combinational N-input, N-bit mux.
- Multiplexes NUM_INPUTS valid/ready streams of NUM_BITS each onto one registered output stream.
- Source selection is either external select or round-robin arbitration; the grant is locked for whole packets, delimited by last.
- Sits ahead of CDC FIFOs / synchronizers to funnel several producers into one crossing.

---
 rtl/stream_mux_pkg.sv | 32 +++
 rtl/stream_mux_rr_if.sv | 28 ++
 rtl/mux_N_bit_length.sv | 14 +
 rtl/rr_arbiter.sv | 22 ++
 rtl/stream_mux_rr.sv | 117 +++++++++++
 tb/tb_stream_mux_rr.sv | 279 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/stream_mux_pkg.sv
// Shared types and the rotate-priority pick used by stream_mux_rr.
package stream_mux_pkg;

   typedef enum logic {MUX_MODE_SEL = 1'b0, MUX_MODE_RR = 1'b1} mux_mode_e;
   typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_e;

   localparam int unsigned RR_MAX_N = 64;
   localparam int unsigned RR_IDX_W = 6;

   typedef struct packed {
      logic                found;
      logic [RR_IDX_W-1:0] idx;
   } rr_pick_t;

   // First set bit of valid strictly after ptr, wrapping modulo n (n a power of 2).
   function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] valid,
                                        input int unsigned         ptr,
                                        input int unsigned         n);
      rr_pick_t    res;
      int unsigned pos;
      res = '0;
      for (int unsigned k = 1; k <= RR_MAX_N; k++) begin
         pos = (ptr + k) & (n - 1);
         if (k <= n && !res.found && valid[RR_IDX_W'(pos)]) begin
            res.found = 1'b1;
            res.idx   = RR_IDX_W'(pos);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Bundle of the N input streams, the select and the single output stream.
interface stream_mux_rr_if #(
   parameter int unsigned NUM_INPUTS = 8,
   parameter int unsigned NUM_BITS   = 32
);
   localparam int unsigned SEL_W = $clog2(NUM_INPUTS);

   logic [NUM_BITS-1:0]   in_data [NUM_INPUTS];
   logic [NUM_INPUTS-1:0] in_valid;
   logic [NUM_INPUTS-1:0] in_last;
   logic [NUM_INPUTS-1:0] in_ready;
   logic [SEL_W-1:0]      sel;
   logic [NUM_BITS-1:0]   out_data;
   logic                  out_last;
   logic [SEL_W-1:0]      out_src;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      output in_data, in_valid, in_last, sel, out_ready,
      input  in_ready, out_data, out_last, out_src, out_valid
   );

   modport slave (
      input  in_data, in_valid, in_last, sel, out_ready,
      output in_ready, out_data, out_last, out_src, out_valid
   );
endinterface

// File: rtl/mux_N_bit_length.sv
// Plain N-input data mux; the index picks one channel word.
module mux_N_bit_length #(
   parameter  int unsigned NUM_INPUTS = 8,
   parameter  int unsigned NUM_BITS   = 32,
   localparam int unsigned SEL_W      = $clog2(NUM_INPUTS)
) (
   input  logic [NUM_BITS-1:0] data_in [NUM_INPUTS],
   input  logic [SEL_W-1:0]    sel,
   output logic [NUM_BITS-1:0] data_out
);

   assign data_out = data_in[sel];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority pick: first valid channel after ptr.
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter  int unsigned NUM_INPUTS = 8,
   localparam int unsigned SEL_W      = $clog2(NUM_INPUTS)
) (
   input  logic [NUM_INPUTS-1:0] valid,
   input  logic [SEL_W-1:0]      ptr,
   output logic [SEL_W-1:0]      grant_c,
   output logic                  found_c
);

   rr_pick_t pick_c;

   always_comb begin
      pick_c  = rr_pick(RR_MAX_N'(valid), 32'(ptr), NUM_INPUTS);
      grant_c = SEL_W'(pick_c.idx);
      found_c = pick_c.found;
   end

endmodule

// File: rtl/stream_mux_rr.sv
// Funnels N valid/ready streams into one registered stream; the grant is held
// for a whole packet and chosen by external select or round-robin.
module stream_mux_rr
   import stream_mux_pkg::*;
#(
   parameter  int unsigned NUM_INPUTS = 8,
   parameter  int unsigned NUM_BITS   = 32,
   parameter  mux_mode_e   MODE       = MUX_MODE_RR,
   localparam int unsigned SEL_W      = $clog2(NUM_INPUTS)
) (
   input logic             clk,
   input logic             rst_n,
   stream_mux_rr_if.slave  bus
);

   lock_state_e           lock_q, lock_d;
   logic [SEL_W-1:0]      lock_idx_q, lock_idx_d;
   logic [SEL_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic                  out_valid_q, out_valid_d;
   logic                  out_last_q, out_last_d;
   logic [SEL_W-1:0]      out_src_q, out_src_d;
   logic [NUM_BITS-1:0]   out_data_q, out_data_d;

   logic [SEL_W-1:0]      rr_grant_c, grant_c;
   logic                  rr_found_c, load_c, gnt_ok_c, xfer_c, gnt_last_c;
   logic [NUM_BITS-1:0]   gnt_data_c;
   logic [NUM_INPUTS-1:0] in_ready_c;

   rr_arbiter #(.NUM_INPUTS(NUM_INPUTS)) u_arb (
      .valid   (bus.in_valid),
      .ptr     (rr_ptr_q),
      .grant_c (rr_grant_c),
      .found_c (rr_found_c)
   );

   mux_N_bit_length #(.NUM_INPUTS(NUM_INPUTS), .NUM_BITS(NUM_BITS)) u_mux (
      .data_in  (bus.in_data),
      .sel      (grant_c),
      .data_out (gnt_data_c)
   );

   // Grant and handshake; in_ready never looks at in_data.
   always_comb begin
      load_c = ~out_valid_q | bus.out_ready;
      if (lock_q == LOCKED) begin
         grant_c  = lock_idx_q;
         gnt_ok_c = bus.in_valid[lock_idx_q];
      end else if (MODE == MUX_MODE_SEL) begin
         grant_c  = bus.sel;
         gnt_ok_c = bus.in_valid[bus.sel];
      end else begin
         grant_c  = rr_grant_c;
         gnt_ok_c = rr_found_c;
      end
      xfer_c     = load_c & gnt_ok_c;
      gnt_last_c = bus.in_last[grant_c];
      in_ready_c = '0;
      if (xfer_c) in_ready_c[grant_c] = 1'b1;
   end

   always_comb begin
      lock_d      = lock_q;
      lock_idx_d  = lock_idx_q;
      rr_ptr_d    = rr_ptr_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_src_d   = out_src_q;
      out_data_d  = out_data_q;

      case (lock_q)
         UNLOCKED: if (xfer_c && !gnt_last_c) begin
            lock_d     = LOCKED;
            lock_idx_d = grant_c;
         end
         LOCKED: if (xfer_c && gnt_last_c) lock_d = UNLOCKED;
         default: lock_d = UNLOCKED;
      endcase

      if (xfer_c && gnt_last_c) rr_ptr_d = grant_c;

      if (xfer_c) begin
         out_valid_d = 1'b1;
         out_data_d  = gnt_data_c;
         out_last_d  = gnt_last_c;
         out_src_d   = grant_c;
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_q      <= UNLOCKED;
         lock_idx_q  <= '0;
         rr_ptr_q    <= SEL_W'(NUM_INPUTS - 1);
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_src_q   <= '0;
         out_data_q  <= '0;
      end else begin
         lock_q      <= lock_d;
         lock_idx_q  <= lock_idx_d;
         rr_ptr_q    <= rr_ptr_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_src_q   <= out_src_d;
         out_data_q  <= out_data_d;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: one round-robin and one external-select instance.
module tb_stream_mux_rr;
   import stream_mux_pkg::*;

   localparam int unsigned N  = 4;
   localparam int unsigned W  = 8;
   localparam int unsigned SW = 2;

   typedef struct packed { logic [W-1:0] data; logic last; } beat_t;
   typedef struct packed { logic [SW-1:0] src; logic [W-1:0] data; logic last; } exp_t;
   typedef struct packed { logic [N-1:0] valid; logic [N-1:0] rdy; logic [SW-1:0] src; } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   stream_mux_rr_if #(.NUM_INPUTS(N), .NUM_BITS(W)) bus_rr ();
   stream_mux_rr_if #(.NUM_INPUTS(N), .NUM_BITS(W)) bus_sel ();

   stream_mux_rr #(.NUM_INPUTS(N), .NUM_BITS(W), .MODE(MUX_MODE_RR)) u_rr (
      .clk(clk), .rst_n(rst_n), .bus(bus_rr));
   stream_mux_rr #(.NUM_INPUTS(N), .NUM_BITS(W), .MODE(MUX_MODE_SEL)) u_sel (
      .clk(clk), .rst_n(rst_n), .bus(bus_sel));

   // Producer queues: index d*N+ch, d=0 round-robin DUT, d=1 select DUT.
   beat_t pq[2*N][$];
   exp_t  eq0[$];
   exp_t  eq1[$];

   logic          ordy;
   logic [SW-1:0] sel_v;
   logic          ov [2];
   logic [W-1:0]  od [2];
   logic          ol [2];
   logic [SW-1:0] os [2];
   logic [N-1:0]  rdy [2];

   int total = 0;
   int bad   = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (pq[i].size() != 0) begin
            bus_rr.in_valid[i] = 1'b1;
            bus_rr.in_data[i]  = pq[i][0].data;
            bus_rr.in_last[i]  = pq[i][0].last;
         end else begin
            bus_rr.in_valid[i] = 1'b0;
            bus_rr.in_data[i]  = '0;
            bus_rr.in_last[i]  = 1'b0;
         end
         if (pq[N+i].size() != 0) begin
            bus_sel.in_valid[i] = 1'b1;
            bus_sel.in_data[i]  = pq[N+i][0].data;
            bus_sel.in_last[i]  = pq[N+i][0].last;
         end else begin
            bus_sel.in_valid[i] = 1'b0;
            bus_sel.in_data[i]  = '0;
            bus_sel.in_last[i]  = 1'b0;
         end
      end
      bus_rr.sel        = sel_v;
      bus_sel.sel       = sel_v;
      bus_rr.out_ready  = ordy;
      bus_sel.out_ready = ordy;
   endtask

   task automatic clear_all();
      for (int i = 0; i < 2*N; i++) pq[i].delete();
      eq0.delete();
      eq1.delete();
   endtask

   function automatic void mon(int d);
      exp_t e;
      if (ov[d] && ordy) begin
         if ((d == 0 && eq0.size() == 0) || (d == 1 && eq1.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat dut%0d: got src=%0d data=%0h, none expected", d, os[d], od[d]);
         end else begin
            e = (d == 0) ? eq0.pop_front() : eq1.pop_front();
            chk($sformatf("beat_dut%0d", d), 32'({os[d], od[d], ol[d]}), 32'(e));
         end
      end
   endfunction

   // Sample just after the falling edge, then advance one full clock.
   task automatic tick();
      logic [N-1:0] hs0, hs1;
      #1;
      ov[0] = bus_rr.out_valid;  od[0] = bus_rr.out_data;  ol[0] = bus_rr.out_last;  os[0] = bus_rr.out_src;
      ov[1] = bus_sel.out_valid; od[1] = bus_sel.out_data; ol[1] = bus_sel.out_last; os[1] = bus_sel.out_src;
      rdy[0] = bus_rr.in_ready;
      rdy[1] = bus_sel.in_ready;
      hs0 = bus_rr.in_valid & bus_rr.in_ready;
      hs1 = bus_sel.in_valid & bus_sel.in_ready;
      mon(0);
      mon(1);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         if (hs0[i]) void'(pq[i].pop_front());
         if (hs1[i]) void'(pq[N+i].pop_front());
      end
      drive();
   endtask

   task automatic drain(string name, int limit);
      int n = 0;
      while ((eq0.size() != 0 || eq1.size() != 0) && n < limit) begin
         tick();
         n++;
      end
      chk({name, "_drained"}, 32'(eq0.size() + eq1.size()), 0);
   endtask

   task automatic sync_reset();
      clear_all();
      drive();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      vec_t tbl[10];
      int   vcnt;

      // Round-robin grant vectors, single-beat packets, starting from ptr=3.
      tbl[0] = '{valid: 4'b0000, rdy: 4'b0000, src: 2'd0};
      tbl[1] = '{valid: 4'b0101, rdy: 4'b0001, src: 2'd0};
      tbl[2] = '{valid: 4'b0101, rdy: 4'b0100, src: 2'd2};
      tbl[3] = '{valid: 4'b0011, rdy: 4'b0001, src: 2'd0};
      tbl[4] = '{valid: 4'b1000, rdy: 4'b1000, src: 2'd3};
      tbl[5] = '{valid: 4'b1000, rdy: 4'b1000, src: 2'd3};
      tbl[6] = '{valid: 4'b0110, rdy: 4'b0010, src: 2'd1};
      tbl[7] = '{valid: 4'b1111, rdy: 4'b0100, src: 2'd2};
      tbl[8] = '{valid: 4'b1011, rdy: 4'b1000, src: 2'd3};
      tbl[9] = '{valid: 4'b0010, rdy: 4'b0010, src: 2'd1};

      rst_n = 1'b0;
      ordy  = 1'b1;
      sel_v = '0;
      clear_all();
      drive();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < 5; k++) begin
         tick();
         chk("idle_out_valid_rr", 32'(ov[0]), 0);
         chk("idle_out_valid_sel", 32'(ov[1]), 0);
         chk("idle_out_data_rr", 32'(od[0]), 0);
         chk("idle_in_ready_rr", 32'(rdy[0]), 0);
      end

      for (int k = 0; k < 10; k++) begin
         for (int i = 0; i < N; i++) begin
            pq[i].delete();
            if (tbl[k].valid[i]) pq[i].push_back('{data: W'(k*16 + i), last: 1'b1});
         end
         if (tbl[k].rdy != '0) eq0.push_back('{src: tbl[k].src, data: W'(k*16 + int'(tbl[k].src)), last: 1'b1});
         drive();
         tick();
         chk($sformatf("tbl%0d_in_ready", k), 32'(rdy[0]), 32'(tbl[k].rdy));
      end
      for (int i = 0; i < N; i++) pq[i].delete();
      drive();
      drain("tbl", 5);

      // Fairness: two single-beat packets on every channel, no bubbles.
      sync_reset();
      for (int c = 0; c < N; c++)
         for (int k = 0; k < 2; k++) pq[c].push_back('{data: W'(8'hA0 + c*2 + k), last: 1'b1});
      for (int k = 0; k < 2; k++)
         for (int c = 0; c < N; c++) eq0.push_back('{src: SW'(c), data: W'(8'hA0 + c*2 + k), last: 1'b1});
      drive();
      vcnt = 0;
      for (int t = 0; t < 9; t++) begin
         tick();
         if (ov[0]) vcnt++;
      end
      chk("rr_no_bubble_cnt", 32'(vcnt), 8);
      chk("rr_fair_drained", 32'(eq0.size()), 0);

      // Packet lock on ch2 while ch0/ch1 wait; ptr=2 then serves ch0.
      pq[2].push_back('{data: 8'hC1, last: 1'b0});
      pq[2].push_back('{data: 8'hC2, last: 1'b0});
      pq[2].push_back('{data: 8'hC3, last: 1'b1});
      eq0.push_back('{src: 2'd2, data: 8'hC1, last: 1'b0});
      eq0.push_back('{src: 2'd2, data: 8'hC2, last: 1'b0});
      eq0.push_back('{src: 2'd2, data: 8'hC3, last: 1'b1});
      eq0.push_back('{src: 2'd0, data: 8'hD0, last: 1'b1});
      eq0.push_back('{src: 2'd1, data: 8'hD1, last: 1'b1});
      drive();
      tick();
      pq[0].push_back('{data: 8'hD0, last: 1'b1});
      pq[1].push_back('{data: 8'hD1, last: 1'b1});
      drive();
      tick();
      chk("lock_in_ready", 32'(rdy[0]), 32'h4);
      drain("lock", 12);

      // Backpressure mid-packet on ch1 with ch3 waiting.
      for (int k = 0; k < 4; k++) begin
         pq[1].push_back('{data: W'(8'h50 + k), last: (k == 3)});
         eq0.push_back('{src: 2'd1, data: W'(8'h50 + k), last: (k == 3)});
      end
      eq0.push_back('{src: 2'd3, data: 8'h60, last: 1'b1});
      drive();
      tick();
      pq[3].push_back('{data: 8'h60, last: 1'b1});
      drive();
      tick();
      ordy = 1'b0;
      drive();
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("bp_out_valid", 32'(ov[0]), 1);
         chk("bp_out_data", 32'(od[0]), 32'h51);
         chk("bp_in_ready", 32'(rdy[0]), 0);
      end
      ordy = 1'b1;
      drive();
      drain("bp", 12);

      // External select: sel moves to 3 mid-packet, ch1 keeps the lock.
      sel_v = 2'd1;
      pq[N+1].push_back('{data: 8'h71, last: 1'b0});
      pq[N+1].push_back('{data: 8'h72, last: 1'b1});
      pq[N+3].push_back('{data: 8'h73, last: 1'b1});
      eq1.push_back('{src: 2'd1, data: 8'h71, last: 1'b0});
      eq1.push_back('{src: 2'd1, data: 8'h72, last: 1'b1});
      eq1.push_back('{src: 2'd3, data: 8'h73, last: 1'b1});
      drive();
      tick();
      chk("sel_first_in_ready", 32'(rdy[1]), 32'h2);
      sel_v = 2'd3;
      drive();
      tick();
      chk("sel_locked_in_ready", 32'(rdy[1]), 32'h2);
      drain("sel", 8);

      // Async reset while ch1 holds a lock and out_valid=1.
      pq[1].push_back('{data: 8'h81, last: 1'b0});
      pq[1].push_back('{data: 8'h82, last: 1'b1});
      drive();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("areset_out_valid", 32'(bus_rr.out_valid), 0);
      chk("areset_out_data", 32'(bus_rr.out_data), 0);
      chk("areset_out_src", 32'(bus_rr.out_src), 0);
      clear_all();
      drive();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < N; c++) begin
         pq[c].push_back('{data: W'(8'h90 + c), last: 1'b1});
         eq0.push_back('{src: SW'(c), data: W'(8'h90 + c), last: 1'b1});
      end
      drive();
      drain("post_reset", 10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
